// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C read engine.
package i2c_pkg;

  localparam int unsigned I2C_DATA_BITS       = 8;
  localparam int unsigned HALF_PERIOD_DEFAULT = 250;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBitLow,
    StBitHigh,
    StStopLow,
    StStopHigh,
    StBusFree
  } state_e;

endpackage

// File: rtl/i2c_tick_gen.sv
// Half-period timer: counts 0..HALF_PERIOD-1 and pulses phase_end on the last count.
module i2c_tick_gen #(
  parameter int unsigned HALF_PERIOD = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase_end
);

  localparam int unsigned CntW = $clog2(HALF_PERIOD);
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign phase_end = !clear && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || phase_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_byte_reader.sv
// Single-master I2C byte reader: START, 8 data clocks plus ACK/NACK slot, STOP, bus-free gap.
module i2c_byte_reader
  import i2c_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       scl,
  inout  wire        sda
);

  localparam logic [3:0] AckSlot = 4'(I2C_DATA_BITS);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       phase_end;
  logic       sda_in;

  i2c_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == StIdle),
    .phase_end(phase_end)
  );

  // Anything other than a solid low (released, pulled up) reads as 1.
  assign sda_in = (sda != 1'b0);
  assign sda    = sda_oe_q ? 1'b0 : 1'bz;

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign scl     = scl_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A request coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          ack_d     = ack_en;
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: if (phase_end) state_d = StBitLow;
      StBitLow: if (phase_end) state_d = StBitHigh;
      StBitHigh: begin
        if (phase_end) begin
          if (bit_cnt_q == AckSlot) begin
            state_d = StStopLow;
          end else begin
            shift_d   = {shift_q[I2C_DATA_BITS-2:0], sda_in};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = StBitLow;
          end
        end
      end
      StStopLow: if (phase_end) state_d = StStopHigh;
      StStopHigh: if (phase_end) state_d = StBusFree;
      StBusFree: begin
        if (phase_end) begin
          rx_data_d = shift_q;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin levels are decoded from the next state so they register in step with it.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    unique case (state_d)
      StStart: sda_oe_d = 1'b1;
      StBitLow: begin
        scl_d    = 1'b0;
        sda_oe_d = (bit_cnt_d == AckSlot) && ack_d;
      end
      StBitHigh: sda_oe_d = (bit_cnt_d == AckSlot) && ack_d;
      StStopLow: begin
        scl_d    = 1'b0;
        sda_oe_d = 1'b1;
      end
      StStopHigh: sda_oe_d = 1'b1;
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_byte_reader.sv
// Self-checking bench: slave model on the pulled-up SDA line, bus monitor and expectation model.
module tb_i2c_byte_reader;

  localparam int unsigned HP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack_en;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       scl;
  wire        sda;
  logic       sda_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda_v = (sda !== 1'b0);

  i2c_byte_reader #(
    .HALF_PERIOD(HP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ack_en (ack_en),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data),
    .scl    (scl),
    .sda    (sda)
  );

  // Slave: after START, each SCL fall presents the next bit MSB first; the 9th fall releases.
  logic       slave_en = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic       slave_drv = 1'b0;
  logic       slave_act = 1'b0;
  int         slave_k = 0;
  logic       s_scl_p = 1'b1;
  logic       s_sda_p = 1'b1;

  assign sda = (slave_drv && !reset) ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    s_scl_p <= scl;
    s_sda_p <= sda_v;
    if (reset) begin
      slave_act <= 1'b0;
      slave_drv <= 1'b0;
      slave_k   <= 0;
    end else if (!slave_act) begin
      if (slave_en && s_scl_p && scl && s_sda_p && !sda_v) begin
        slave_act <= 1'b1;
        slave_k   <= 0;
      end
    end else if (s_scl_p && !scl) begin
      if (slave_k < 8) begin
        slave_drv <= !slave_byte[7-slave_k];
      end else begin
        slave_drv <= 1'b0;
        slave_act <= 1'b0;
      end
      slave_k <= slave_k + 1;
    end
  end

  // Bus monitor statistics for one transfer.
  logic clr_mon = 1'b0;
  logic scl_p = 1'b1;
  logic sda_p = 1'b1;
  int   rises, busy_cycles, done_cnt, fall_hi, rise_hi, width_err, seg_len, ack_low, scl_low_cnt;

  always @(negedge clk) begin
    scl_p <= scl;
    sda_p <= sda_v;
    if (clr_mon) begin
      rises       <= 0;
      busy_cycles <= 0;
      done_cnt    <= 0;
      fall_hi     <= 0;
      rise_hi     <= 0;
      width_err   <= 0;
      seg_len     <= 1;
      ack_low     <= 0;
      scl_low_cnt <= 0;
    end else begin
      if (busy) busy_cycles <= busy_cycles + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (!scl) scl_low_cnt <= scl_low_cnt + 1;
      if (scl_p && scl && sda_p && !sda_v) fall_hi <= fall_hi + 1;
      if (scl_p && scl && !sda_p && sda_v) rise_hi <= rise_hi + 1;
      if (scl_p && scl && rises == 9 && !sda_v) ack_low <= ack_low + 1;
      if (scl != scl_p) begin
        if (scl) rises <= rises + 1;
        // Lows are always bounded; highs only once they started from a low.
        if ((!scl_p || rises > 0) && seg_len != HP) width_err <= width_err + 1;
        seg_len <= 1;
      end else begin
        seg_len <= seg_len + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    clr_mon = 1'b1;
    step();
    clr_mon = 1'b0;
  endtask

  // One read; exp_rx comes from the caller's model. poke adds start pulses mid-byte and on done.
  task automatic run_xfer(input logic [7:0] b, input logic a, input logic sl,
                          input logic [7:0] exp_rx, input logic poke);
    logic seen;
    slave_byte = b;
    slave_en   = sl;
    clear_monitor();
    start  = 1'b1;
    ack_en = a;
    step();
    start  = 1'b0;
    ack_en = ~a;
    check("busy_after_start", busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 30 * HP && !seen; i++) begin
      start = poke && (i == 5 * HP);
      step();
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("rx_data", rx_data, exp_rx);
    if (poke) begin
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_on_done_ignored", busy, 0);
      step();
      check("still_idle", busy, 0);
    end
    repeat (3) step();
    check("done_count", done_cnt, 1);
    check("busy_cycles", busy_cycles, 22 * HP);
    check("scl_rises", rises, 10);  // 9 bit clocks + STOP
    check("sda_fall_scl_hi", fall_hi, 1);
    check("sda_rise_scl_hi", rise_hi, 1);
    check("scl_width_err", width_err, 0);
    check("ack_slot_low", ack_low, a ? HP - 1 : 0);
  endtask

  typedef struct {
    logic [7:0] slave_byte;
    logic       ack;
    logic       slave_en;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] b;
    logic       a;
    logic       sl;
    logic       hit;

    vecs[0] = '{slave_byte: 8'h5A, ack: 1'b1, slave_en: 1'b1, exp_rx: 8'h5A};
    vecs[1] = '{slave_byte: 8'h12, ack: 1'b0, slave_en: 1'b0, exp_rx: 8'hFF};
    vecs[2] = '{slave_byte: 8'h00, ack: 1'b1, slave_en: 1'b1, exp_rx: 8'h00};
    vecs[3] = '{slave_byte: 8'h99, ack: 1'b0, slave_en: 1'b1, exp_rx: 8'h99};

    reset  = 1'b1;
    start  = 1'b0;
    ack_en = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 8'h00);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_v, 1);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].slave_byte, vecs[i].ack, vecs[i].slave_en, vecs[i].exp_rx, 1'b0);
    end

    // Reset during the low phase of data bit 4; rx_data currently holds 8'h99.
    slave_byte = 8'hC3;
    slave_en   = 1'b1;
    clear_monitor();
    start  = 1'b1;
    ack_en = 1'b0;
    step();
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 30 * HP && !hit; i++) begin
      step();
      if (rises == 3 && !scl) hit = 1'b1;
    end
    check("reach_bit4", hit, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_scl", scl, 1);
    check("midrst_sda", sda_v, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rx", rx_data, 8'h00);
    clear_monitor();
    repeat (3 * HP) step();
    check("midrst_no_stop", scl_low_cnt, 0);
    check("midrst_no_busy", busy_cycles, 0);
    run_xfer(8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0);

    // Extra start pulses mid-byte and in the done cycle must not trigger a second read.
    run_xfer(8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1);

    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      a  = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 3) != 0);
      run_xfer(b, a, sl, sl ? b : 8'hFF, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
